rgb_to_yuv_encoder: RTL and testbench



---
 rtl/rgb_to_yuv_encoder_if.sv | 28 ++
 rtl/rgb_to_yuv_encoder.sv | 234 +++++++++++++++++++++++
 tb/tb_rgb_to_yuv_encoder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_to_yuv_encoder_if.sv
// SRAM port and frame handshake between the RGB-to-YUV encoder and the memory side.
// The encoder takes the master modport; the SRAM/controller side takes the slave modport.
interface rgb_to_yuv_encoder_if;
    logic        startF;
    logic        endF;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;

    modport master (
        input  startF,
        input  SRAM_read_data,
        output endF,
        output SRAM_address,
        output SRAM_write_data,
        output SRAM_we_n
    );

    modport slave (
        output startF,
        output SRAM_read_data,
        input  endF,
        input  SRAM_address,
        input  SRAM_write_data,
        input  SRAM_we_n
    );
endinterface

// File: rtl/rgb_to_yuv_encoder.sv
// Frame encoder: reads interleaved RGB from SRAM, converts 4-pixel groups to BT.601 Y/U/V
// with 2:1 horizontal chroma decimation, and writes the packed planes back (20 cycles/group).
module rgb_to_yuv_encoder #(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter logic [17:0] Y_BASE     = 18'd0,
    parameter logic [17:0] U_BASE     = 18'd38400,
    parameter logic [17:0] V_BASE     = 18'd57600,
    parameter logic [17:0] RGB_BASE   = 18'd146944
) (
    input  logic                        Clock,
    input  logic                        Reset,
    rgb_to_yuv_encoder_if.master        bus
);

    localparam int unsigned N_GROUPS = (IMG_WIDTH * IMG_HEIGHT) / 4;
    localparam int unsigned GRP_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(N_GROUPS - 1);

    localparam logic signed [31:0] C_YR =  32'sd16843;
    localparam logic signed [31:0] C_YG =  32'sd33030;
    localparam logic signed [31:0] C_YB =  32'sd6423;
    localparam logic signed [31:0] C_UR = -32'sd9699;
    localparam logic signed [31:0] C_UG = -32'sd19071;
    localparam logic signed [31:0] C_UB =  32'sd28770;
    localparam logic signed [31:0] C_VR =  32'sd28770;
    localparam logic signed [31:0] C_VG = -32'sd24117;
    localparam logic signed [31:0] C_VB = -32'sd4653;
    localparam logic signed [31:0] OFF_Y  = (32'sd16  <<< 16) + 32'sd32768;
    localparam logic signed [31:0] OFF_UV = (32'sd128 <<< 16) + 32'sd32768;
    localparam logic signed [31:0] ACC_SAT = 32'sd16777216;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CALC,
        S_WRITE
    } state_e;

    state_e            state_q;
    logic [2:0]        phase_q;
    logic [GRP_W-1:0]  grp_q;
    logic [17:0]       rgb_q;
    logic [17:0]       ycnt_q;
    logic [17:0]       ucnt_q;
    logic [17:0]       vcnt_q;
    logic [17:0]       addr_q;
    logic [15:0]       wdata_q;
    logic              we_n_q;
    logic              endf_q;
    logic [5:0][15:0]  word_q;
    logic [3:0][7:0]   yres_q;
    logic [1:0][7:0]   ures_q;
    logic [1:0][7:0]   vres_q;

    logic [7:0]         rgb_byte [12];
    logic [1:0]         pix_sel;
    logic [7:0]         pix_r, pix_g, pix_b;
    logic signed [31:0] coef_r, coef_g, coef_b, offset;
    logic signed [31:0] opr_r, opr_g, opr_b;
    logic signed [31:0] prod_r, prod_g, prod_b;
    logic signed [31:0] acc;
    logic [7:0]         conv_d;

    // The six source words are shifted in oldest-first, so word 0 ends up in word_q[5].
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            rgb_byte[2*i]   = word_q[5-i][15:8];
            rgb_byte[2*i+1] = word_q[5-i][7:0];
        end
    end

    // C0..C3 pick pixels 0..3 for Y; C4..C7 pick pixel 0 or 2 for chroma.
    always_comb begin
        pix_sel = phase_q[2] ? {phase_q[0], 1'b0} : phase_q[1:0];
        pix_r   = rgb_byte[0];
        pix_g   = rgb_byte[1];
        pix_b   = rgb_byte[2];
        unique case (pix_sel)
            2'd0: begin pix_r = rgb_byte[0]; pix_g = rgb_byte[1];  pix_b = rgb_byte[2];  end
            2'd1: begin pix_r = rgb_byte[3]; pix_g = rgb_byte[4];  pix_b = rgb_byte[5];  end
            2'd2: begin pix_r = rgb_byte[6]; pix_g = rgb_byte[7];  pix_b = rgb_byte[8];  end
            2'd3: begin pix_r = rgb_byte[9]; pix_g = rgb_byte[10]; pix_b = rgb_byte[11]; end
        endcase
    end

    always_comb begin
        coef_r = C_YR;
        coef_g = C_YG;
        coef_b = C_YB;
        offset = OFF_Y;
        if (phase_q[2]) begin
            offset = OFF_UV;
            if (phase_q[1]) begin
                coef_r = C_VR;
                coef_g = C_VG;
                coef_b = C_VB;
            end else begin
                coef_r = C_UR;
                coef_g = C_UG;
                coef_b = C_UB;
            end
        end
    end

    // Three shared signed multipliers; one Y, U or V sample per cycle.
    always_comb begin
        opr_r  = $signed({24'd0, pix_r});
        opr_g  = $signed({24'd0, pix_g});
        opr_b  = $signed({24'd0, pix_b});
        prod_r = coef_r * opr_r;
        prod_g = coef_g * opr_g;
        prod_b = coef_b * opr_b;
        acc    = prod_r + prod_g + prod_b + offset;
        if (acc < 32'sd0) begin
            conv_d = 8'd0;
        end else if (acc >= ACC_SAT) begin
            conv_d = 8'd255;
        end else begin
            conv_d = acc[23:16];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            phase_q <= 3'd0;
            grp_q   <= '0;
            rgb_q   <= RGB_BASE;
            ycnt_q  <= Y_BASE;
            ucnt_q  <= U_BASE;
            vcnt_q  <= V_BASE;
            addr_q  <= 18'd0;
            wdata_q <= 16'd0;
            we_n_q  <= 1'b1;
            endf_q  <= 1'b0;
            word_q  <= '0;
            yres_q  <= '0;
            ures_q  <= '0;
            vres_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    we_n_q <= 1'b1;
                    if (bus.startF) begin
                        endf_q  <= 1'b0;
                        grp_q   <= '0;
                        ycnt_q  <= Y_BASE;
                        ucnt_q  <= U_BASE;
                        vcnt_q  <= V_BASE;
                        addr_q  <= RGB_BASE;
                        rgb_q   <= RGB_BASE + 18'd1;
                        phase_q <= 3'd0;
                        state_q <= S_READ;
                    end
                end

                // R0..R5 present addresses; data returns two cycles later (R2..R7).
                S_READ: begin
                    we_n_q <= 1'b1;
                    if (phase_q <= 3'd4) begin
                        addr_q <= rgb_q;
                        rgb_q  <= rgb_q + 18'd1;
                    end
                    if (phase_q >= 3'd2) begin
                        word_q <= {word_q[4:0], bus.SRAM_read_data};
                    end
                    phase_q <= phase_q + 3'd1;
                    if (phase_q == 3'd7) begin
                        state_q <= S_CALC;
                    end
                end

                S_CALC: begin
                    if (!phase_q[2]) begin
                        yres_q[phase_q[1:0]] <= conv_d;
                    end else if (!phase_q[1]) begin
                        ures_q[phase_q[0]] <= conv_d;
                    end else begin
                        vres_q[phase_q[0]] <= conv_d;
                    end
                    phase_q <= phase_q + 3'd1;
                    if (phase_q == 3'd7) begin
                        state_q <= S_WRITE;
                        we_n_q  <= 1'b0;
                        addr_q  <= ycnt_q;
                        ycnt_q  <= ycnt_q + 18'd1;
                        wdata_q <= {yres_q[0], yres_q[1]};
                    end
                end

                S_WRITE: begin
                    phase_q <= phase_q + 3'd1;
                    unique case (phase_q[1:0])
                        2'd0: begin
                            addr_q  <= ycnt_q;
                            ycnt_q  <= ycnt_q + 18'd1;
                            wdata_q <= {yres_q[2], yres_q[3]};
                        end
                        2'd1: begin
                            addr_q  <= ucnt_q;
                            ucnt_q  <= ucnt_q + 18'd1;
                            wdata_q <= {ures_q[0], ures_q[1]};
                        end
                        2'd2: begin
                            addr_q  <= vcnt_q;
                            vcnt_q  <= vcnt_q + 18'd1;
                            wdata_q <= {vres_q[0], vres_q[1]};
                        end
                        2'd3: begin
                            we_n_q  <= 1'b1;
                            phase_q <= 3'd0;
                            if (grp_q == LAST_GRP) begin
                                endf_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                grp_q   <= grp_q + GRP_W'(1);
                                addr_q  <= rgb_q;
                                rgb_q   <= rgb_q + 18'd1;
                                state_q <= S_READ;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign bus.endF            = endf_q;
    assign bus.SRAM_address    = addr_q;
    assign bus.SRAM_write_data = wdata_q;
    assign bus.SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Self-checking bench for rgb_to_yuv_encoder on a reduced 8x4 frame placed at the top of SRAM.
module tb_rgb_to_yuv_encoder;

    localparam int unsigned IW = 8;
    localparam int unsigned IH = 4;
    localparam int          G  = (IW * IH) / 4;
    localparam logic [17:0] YB = 18'd0;
    localparam logic [17:0] UB = 18'd38400;
    localparam logic [17:0] VB = 18'd57600;
    localparam logic [17:0] RB = 18'd262144 - 18'(6 * G);

    typedef struct {
        int          c;
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [15:0] mem [0:262143];
    logic [17:0] ad1 = 18'd0;
    logic [17:0] ad2 = 18'd0;
    wr_t         wlog [$];
    wr_t         ew   [$];
    logic [17:0] alog [int];

    rgb_to_yuv_encoder_if bus ();

    rgb_to_yuv_encoder #(
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .Y_BASE     (YB),
        .U_BASE     (UB),
        .V_BASE     (VB),
        .RGB_BASE   (RB)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial forever #10 Clock = ~Clock;

    // Two-cycle SRAM read pipeline.
    always @(posedge Clock) begin
        cyc <= cyc + 1;
        ad1 <= bus.SRAM_address;
        ad2 <= ad1;
    end
    assign bus.SRAM_read_data = mem[ad2];

    always @(negedge Clock) begin
        alog[cyc] = bus.SRAM_address;
        if (bus.SRAM_we_n === 1'b0) begin
            wlog.push_back('{cyc, bus.SRAM_address, bus.SRAM_write_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Studio-range conversion: floor of the Q16 sum, clamped to a byte.
    function automatic logic [7:0] conv(input int kr, input int kg, input int kb,
                                        input int base, input int r, input int g, input int b);
        int s;
        int q;
        s = kr * r + kg * g + kb * b + base * 65536 + 32768;
        q = (s >= 0) ? (s / 65536) : -1;
        if (q < 0)   return 8'd0;
        if (q > 255) return 8'd255;
        return 8'(q);
    endfunction

    function automatic void build_exp(input int t0);
        int          px [12];
        logic [15:0] w;
        logic [7:0]  y [4];
        logic [7:0]  u0, u2, v0, v2;
        ew.delete();
        for (int g = 0; g < G; g++) begin
            for (int k = 0; k < 6; k++) begin
                w = mem[int'(RB) + 6 * g + k];
                px[2*k]   = int'(w[15:8]);
                px[2*k+1] = int'(w[7:0]);
            end
            for (int p = 0; p < 4; p++) begin
                y[p] = conv(16843, 33030, 6423, 16, px[3*p], px[3*p+1], px[3*p+2]);
            end
            u0 = conv(-9699, -19071, 28770, 128, px[0], px[1], px[2]);
            u2 = conv(-9699, -19071, 28770, 128, px[6], px[7], px[8]);
            v0 = conv(28770, -24117, -4653, 128, px[0], px[1], px[2]);
            v2 = conv(28770, -24117, -4653, 128, px[6], px[7], px[8]);
            ew.push_back('{t0 + 20*g + 16, 18'(int'(YB) + 2*g),     {y[0], y[1]}});
            ew.push_back('{t0 + 20*g + 17, 18'(int'(YB) + 2*g + 1), {y[2], y[3]}});
            ew.push_back('{t0 + 20*g + 18, 18'(int'(UB) + g),       {u0, u2}});
            ew.push_back('{t0 + 20*g + 19, 18'(int'(VB) + g),       {v0, v2}});
        end
    endfunction

    task automatic run_frame(input string tag, output int t0);
        int n;
        @(negedge Clock);
        wlog.delete();
        bus.startF = 1'b1;
        t0 = cyc + 1;
        @(negedge Clock);
        bus.startF = 1'b0;
        chk({tag, "_endF_clear"}, 32'(bus.endF), 32'd0);
        n = 0;
        while (bus.endF !== 1'b1 && n < 20 * G + 100) begin
            @(negedge Clock);
            n++;
        end
        chk({tag, "_endF_latency"}, 32'(cyc - t0), 32'(20 * G));
        repeat (5) @(negedge Clock);
        chk({tag, "_endF_hold"}, 32'(bus.endF), 32'd1);
        chk({tag, "_idle_we_n"}, 32'(bus.SRAM_we_n), 32'd1);
    endtask

    task automatic verify(input string tag, input int t0);
        build_exp(t0);
        chk({tag, "_write_count"}, 32'(wlog.size()), 32'(ew.size()));
        for (int i = 0; i < ew.size(); i++) begin
            if (i < wlog.size()) begin
                chk($sformatf("%s_wr%0d_addr", tag, i), 32'(wlog[i].a), 32'(ew[i].a));
                chk($sformatf("%s_wr%0d_data", tag, i), 32'(wlog[i].d), 32'(ew[i].d));
                chk($sformatf("%s_wr%0d_cycle", tag, i), 32'(wlog[i].c - t0), 32'(ew[i].c - t0));
            end
        end
        for (int g = 0; g < G; g++) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("%s_rd_g%0d_k%0d", tag, g, k), 32'(alog[t0 + 20*g + k]),
                    32'(int'(RB) + 6*g + k));
            end
        end
    endtask

    task automatic check_flat(input string tag, input logic [15:0] yexp);
        for (int i = 0; i < wlog.size(); i++) begin
            chk($sformatf("%s_flat%0d", tag, i), 32'(wlog[i].d),
                (wlog[i].a < UB) ? 32'(yexp) : 32'h8080);
        end
    endtask

    initial begin
        int t0;
        Reset      = 1'b1;
        bus.startF = 1'b0;
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
        repeat (3) @(negedge Clock);
        chk("reset_we_n", 32'(bus.SRAM_we_n), 32'd1);
        chk("reset_addr", 32'(bus.SRAM_address), 32'd0);
        chk("reset_wdata", 32'(bus.SRAM_write_data), 32'd0);
        chk("reset_endF", 32'(bus.endF), 32'd0);
        Reset = 1'b0;

        // Random frame with the directed first group.
        for (int i = 0; i < 6 * G; i++) mem[int'(RB) + i] = 16'($urandom);
        mem[int'(RB) + 0] = 16'h0000;
        mem[int'(RB) + 1] = 16'h00FF;
        mem[int'(RB) + 2] = 16'hFFFF;
        mem[int'(RB) + 3] = 16'hFF00;
        mem[int'(RB) + 4] = 16'h00FF;
        mem[int'(RB) + 5] = 16'hFFFF;
        run_frame("rand", t0);
        verify("rand", t0);
        if (wlog.size() >= 4) begin
            chk("dir_y0_addr", 32'(wlog[0].a), 32'd0);
            chk("dir_y0_data", 32'(wlog[0].d), 32'h10EB);
            chk("dir_y1_addr", 32'(wlog[1].a), 32'd1);
            chk("dir_y1_data", 32'(wlog[1].d), 32'h52EB);
            chk("dir_u_addr",  32'(wlog[2].a), 32'd38400);
            chk("dir_u_data",  32'(wlog[2].d), 32'h805A);
            chk("dir_v_addr",  32'(wlog[3].a), 32'd57600);
            chk("dir_v_data",  32'(wlog[3].d), 32'h80F0);
        end

        // Restart from endF=1 with the same data.
        run_frame("restart", t0);
        verify("restart", t0);

        for (int i = 0; i < 6 * G; i++) mem[int'(RB) + i] = 16'h0000;
        run_frame("black", t0);
        verify("black", t0);
        check_flat("black", 16'h1010);

        for (int i = 0; i < 6 * G; i++) mem[int'(RB) + i] = 16'hFFFF;
        run_frame("white", t0);
        verify("white", t0);
        check_flat("white", 16'hEBEB);

        // Reset in the middle of S_CALC of the first group.
        for (int i = 0; i < 6 * G; i++) mem[int'(RB) + i] = 16'($urandom);
        @(negedge Clock);
        bus.startF = 1'b1;
        @(negedge Clock);
        bus.startF = 1'b0;
        repeat (10) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("midrst_we_n", 32'(bus.SRAM_we_n), 32'd1);
        chk("midrst_addr", 32'(bus.SRAM_address), 32'd0);
        chk("midrst_endF", 32'(bus.endF), 32'd0);
        wlog.delete();
        repeat (60) @(negedge Clock);
        chk("midrst_no_writes", 32'(wlog.size()), 32'd0);

        run_frame("postrst", t0);
        verify("postrst", t0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
